// File: rtl/core_mon_pkg.sv
// Shared constants for the core liveness monitor: state encodings and widths.
package core_mon_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_WAIT_START = 2'd0;
   localparam logic [STATE_W-1:0] ST_ALIVE      = 2'd1;
   localparam logic [STATE_W-1:0] ST_STALLED    = 2'd2;
   localparam logic [STATE_W-1:0] ST_LOOPING    = 2'd3;

endpackage

// File: rtl/mon_idle_timer.sv
// Idle-cycle counter: counts retire-free cycles while running and flags the
// cycle on which the timeout budget is exhausted.
module mon_idle_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic kick,
   output logic expire
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expire = (count_q == CNT_LAST) && !kick;

   // Clearing on expire keeps the counter from ever wrapping past its last value.
   always_comb begin
      count_d = count_q;
      if (!run || kick || expire) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples its pre-edge inputs regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/core_alive_monitor.sv
// Core liveness monitor: enables the heartbeat only while the core retires
// instructions at changing PCs; stalls and self-loops latch sticky flags.
module core_alive_monitor
   import core_mon_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int LOOP_LIMIT     = 1024,
   parameter int PC_WIDTH       = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                retire_valid,
   input  logic [PC_WIDTH-1:0] retire_pc,
   input  logic                clr,
   output logic                hb_enable,
   output logic                stalled,
   output logic                self_loop,
   output logic [STATE_W-1:0]  state_o
);

   localparam int               LOOP_W   = $clog2(LOOP_LIMIT);
   localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(LOOP_LIMIT - 1);

   logic [STATE_W-1:0]  state_q, state_d;
   logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
   logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
   logic                hb_enable_q, hb_enable_d;
   logic                stalled_q, stalled_d;
   logic                self_loop_q, self_loop_d;

   logic timer_run;
   logic expire;
   logic same_pc;
   logic set_stall;
   logic set_loop;

   assign timer_run = (state_q == ST_ALIVE) || (state_q == ST_LOOPING);
   assign same_pc   = (retire_pc == last_pc_q);

   mon_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (timer_run),
      .kick   (retire_valid),
      .expire (expire)
   );

   // NOTE: every signal assigned here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      loop_cnt_d = loop_cnt_q;
      last_pc_d  = last_pc_q;
      set_stall  = 1'b0;
      set_loop   = 1'b0;

      if (retire_valid) begin
         last_pc_d = retire_pc;
      end

      case (state_q)
         ST_WAIT_START, ST_STALLED: begin
            if (retire_valid) begin
               state_d    = ST_ALIVE;
               loop_cnt_d = '0;
            end
         end
         ST_ALIVE: begin
            if (retire_valid) begin
               if (!same_pc) begin
                  loop_cnt_d = '0;
               end else if (loop_cnt_q == LOOP_MAX) begin
                  state_d  = ST_LOOPING;
                  set_loop = 1'b1;
               end else begin
                  loop_cnt_d = loop_cnt_q + LOOP_W'(1);
               end
            end else if (expire) begin
               state_d   = ST_STALLED;
               set_stall = 1'b1;
            end
         end
         ST_LOOPING: begin
            // A same-PC retire leaves the saturated loop counter untouched.
            if (retire_valid) begin
               if (!same_pc) begin
                  state_d    = ST_ALIVE;
                  loop_cnt_d = '0;
               end
            end else if (expire) begin
               state_d   = ST_STALLED;
               set_stall = 1'b1;
            end
         end
         default: begin
            state_d = ST_WAIT_START;
         end
      endcase

      hb_enable_d = (state_d == ST_ALIVE);
      // A set event in the same cycle as clr takes priority.
      stalled_d   = set_stall ? 1'b1 : (clr ? 1'b0 : stalled_q);
      self_loop_d = set_loop  ? 1'b1 : (clr ? 1'b0 : self_loop_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_WAIT_START;
         loop_cnt_q  <= '0;
         last_pc_q   <= '0;
         hb_enable_q <= 1'b0;
         stalled_q   <= 1'b0;
         self_loop_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         loop_cnt_q  <= loop_cnt_d;
         last_pc_q   <= last_pc_d;
         hb_enable_q <= hb_enable_d;
         stalled_q   <= stalled_d;
         self_loop_q <= self_loop_d;
      end
   end

   assign hb_enable = hb_enable_q;
   assign stalled   = stalled_q;
   assign self_loop = self_loop_q;
   assign state_o   = state_q;

endmodule
